imm_gen_pipe: RTL and testbench

Pipelined, parametrised immediate generator for the decode stage. Extracts and extends the RISC-V immediate selected by `imm_sel` from a 32-bit instruction. Supports XLEN 32 or 64, adds shift-amount and CSR-zimm formats, and registers the result behind a valid/ready handshake with an optional skid buffer. Sits between instruction fetch/decode control and the register-read/execute stage, carrying a sideband tag (typically the PC) alongside each immediate.

---
 rtl/imm_pkg.sv | 20 ++
 rtl/imm_decode.sv | 39 +++
 rtl/imm_gen_pipe.sv | 120 ++++++++++++
 tb/tb_imm_gen_pipe.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared definitions for the pipelined immediate generator:
// format-select codes and the shift-amount width helper.
package imm_pkg;

   // Format-select codes carried on imm_sel.
   localparam logic [2:0] IMM_I     = 3'b000;
   localparam logic [2:0] IMM_IU    = 3'b001;
   localparam logic [2:0] IMM_SHAMT = 3'b010;
   localparam logic [2:0] IMM_S     = 3'b011;
   localparam logic [2:0] IMM_B     = 3'b100;
   localparam logic [2:0] IMM_U     = 3'b101;
   localparam logic [2:0] IMM_J     = 3'b110;
   localparam logic [2:0] IMM_ZIMM  = 3'b111;

   // Shift-amount field width: 5 bits on RV32, 6 bits on RV64.
   function automatic int shamt_w(input int xlen);
      return (xlen == 64) ? 6 : 5;
   endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction and extension for one instruction word.
module imm_decode
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     inst,
   input  logic [2:0]      imm_sel,
   output logic [XLEN-1:0] imm,
   output logic            shamt_err
);

   localparam int SW = shamt_w(XLEN);

   // The opcode field never contributes to an immediate.
   logic unused_opcode;
   assign unused_opcode = ^inst[6:0];

   // Select the field for the requested format and extend it to XLEN.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      imm       = '0;
      shamt_err = 1'b0;
      case (imm_sel)
         IMM_I:     imm = XLEN'($signed(inst[31:20]));
         IMM_IU:    imm = XLEN'(inst[31:20]);
         IMM_SHAMT: begin
            imm       = XLEN'(inst[20 +: SW]);
            shamt_err = (XLEN == 32) && inst[25];
         end
         IMM_S:     imm = XLEN'($signed({inst[31:25], inst[11:7]}));
         IMM_B:     imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
         IMM_U:     imm = XLEN'($signed({inst[31:12], 12'b0}));
         IMM_J:     imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
         default:   imm = XLEN'(inst[19:15]);
      endcase
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes on the input side, then registers
// the decoded beat (immediate, tag, shamt_err) behind a valid/ready handshake,
// with an optional skid register so in_ready can come straight from a flop.
module imm_gen_pipe
   import imm_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32,
   parameter bit SKID  = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      inst,
   input  logic [2:0]       imm_sel,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  imm,
   output logic [TAG_W-1:0] out_tag,
   output logic             shamt_err
);

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      logic [TAG_W-1:0] tag;
      logic             err;
   } beat_t;

   logic [XLEN-1:0] dec_imm;
   logic            dec_err;
   beat_t           in_beat;
   beat_t           m_beat;
   logic            m_valid;
   logic            accept;
   logic            deliver;

   imm_decode #(.XLEN(XLEN)) u_decode (
      .inst      (inst),
      .imm_sel   (imm_sel),
      .imm       (dec_imm),
      .shamt_err (dec_err)
   );

   assign in_beat = '{imm: dec_imm, tag: in_tag, err: dec_err};
   assign accept  = in_valid && in_ready;
   assign deliver = m_valid && out_ready;

   generate
      if (SKID) begin : g_skid
         beat_t s_beat;
         logic  s_valid;
         logic  ready_q;
         logic  m_load;
         logic  s_load;
         logic  s_to_m;
         logic  s_valid_nxt;

         // An accept is only possible with S empty, so M takes it unless M
         // is stalled, in which case it parks in S.
         assign s_to_m      = deliver && s_valid;
         assign m_load      = accept && (!m_valid || deliver);
         assign s_load      = accept && m_valid && !deliver;
         assign s_valid_nxt = s_load || (s_valid && !s_to_m);
         assign in_ready    = ready_q;

         // Main register, skid valid and registered ready.
         always_ff @(posedge clk) begin
            // NOTE: sequential state uses non-blocking assignments only.
            if (rst) begin
               m_valid <= 1'b0;
               m_beat  <= '0;
               s_valid <= 1'b0;
               ready_q <= 1'b0;
            end else begin
               if (s_to_m) begin
                  m_beat <= s_beat;
               end else if (m_load) begin
                  m_valid <= 1'b1;
                  m_beat  <= in_beat;
               end else if (deliver) begin
                  m_valid <= 1'b0;
               end
               s_valid <= s_valid_nxt;
               ready_q <= !s_valid_nxt;
            end
         end

         // Skid payload capture.
         always_ff @(posedge clk) begin
            // NOTE: the skid payload is not reset; s_valid alone decides whether it is live.
            if (s_load) begin
               s_beat <= in_beat;
            end
         end
      end else begin : g_single
         assign in_ready = !rst && (!m_valid || out_ready);

         // Single output register, reloaded on every accept.
         always_ff @(posedge clk) begin
            if (rst) begin
               m_valid <= 1'b0;
               m_beat  <= '0;
            end else if (accept) begin
               m_valid <= 1'b1;
               m_beat  <= in_beat;
            end else if (deliver) begin
               m_valid <= 1'b0;
            end
         end
      end
   endgenerate

   assign out_valid = m_valid;
   assign imm       = m_beat.imm;
   assign out_tag   = m_beat.tag;
   assign shamt_err = m_beat.err;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench: dut_a is XLEN=32 with skid buffer, dut_b is XLEN=64
// single-register. Drivers push expected beats on acceptance; a monitor pops
// and compares on every delivery.
module tb_imm_gen_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] inst;
   logic [2:0]  imm_sel;
   logic [31:0] in_tag;

   logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, err_a;
   logic [31:0] imm_a, tag_a;
   logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, err_b;
   logic [63:0] imm_b;
   logic [31:0] tag_b;

   typedef struct {
      logic [63:0] imm;
      logic [31:0] tag;
      logic        err;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   int   dcyc_a[$];
   int   dcyc_b[$];

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   logic [2:0]  v_sel [13];
   logic [31:0] v_inst[13];
   logic [63:0] v_ea  [13];
   logic        v_erra[13];
   logic [63:0] v_eb  [13];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   imm_gen_pipe #(.XLEN(32), .TAG_W(32), .SKID(1)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .inst(inst), .imm_sel(imm_sel), .in_tag(in_tag),
      .out_valid(out_valid_a), .out_ready(out_ready_a),
      .imm(imm_a), .out_tag(tag_a), .shamt_err(err_a)
   );

   imm_gen_pipe #(.XLEN(64), .TAG_W(32), .SKID(0)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .inst(inst), .imm_sel(imm_sel), .in_tag(in_tag),
      .out_valid(out_valid_b), .out_ready(out_ready_b),
      .imm(imm_b), .out_tag(tag_b), .shamt_err(err_b)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_vec(input int i, input logic [2:0] sel, input logic [31:0] ins,
                          input logic [63:0] ea, input logic erra, input logic [63:0] eb);
      v_sel[i] = sel; v_inst[i] = ins; v_ea[i] = ea; v_erra[i] = erra; v_eb[i] = eb;
   endtask

   // Present one beat to the enabled DUTs; push expectations as each accepts.
   // Called one time unit after a rising edge.
   task automatic send(input bit en_a, input bit en_b, input int idx, input logic [31:0] tag);
      bit pa, pb, ra, rb;
      int n;
      inst = v_inst[idx]; imm_sel = v_sel[idx]; in_tag = tag;
      in_valid_a = en_a; in_valid_b = en_b;
      pa = en_a; pb = en_b; n = 0;
      while ((pa || pb) && n < 50) begin
         ra = in_ready_a; rb = in_ready_b;
         @(posedge clk); #1;
         if (pa && ra) begin
            q_a.push_back('{imm: v_ea[idx], tag: tag, err: v_erra[idx]});
            pa = 0; in_valid_a = 1'b0;
         end
         if (pb && rb) begin
            q_b.push_back('{imm: v_eb[idx], tag: tag, err: 1'b0});
            pb = 0; in_valid_b = 1'b0;
         end
         n++;
      end
      if (pa || pb) check("accept_timeout", {62'b0, pa, pb}, 64'd0);
      in_valid_a = 1'b0; in_valid_b = 1'b0;
   endtask

   // Monitor: compare delivered beats against the scoreboard and check that a
   // stalled output holds its value.
   bit          hold_a = 0, hold_b = 0;
   logic [31:0] h_tag_a, h_imm_a, h_tag_b;
   logic [63:0] h_imm_b;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         hold_a = 0; hold_b = 0;
      end else begin
         if (hold_a) begin
            check("hold_valid_a", out_valid_a, 1);
            check("hold_tag_a", tag_a, h_tag_a);
            check("hold_imm_a", imm_a, h_imm_a);
         end
         if (hold_b) begin
            check("hold_valid_b", out_valid_b, 1);
            check("hold_tag_b", tag_b, h_tag_b);
            check("hold_imm_b", imm_b, h_imm_b);
         end
         if (out_valid_a && out_ready_a) begin
            dcyc_a.push_back(cyc);
            if (q_a.size() == 0) begin
               compared++; mismatched++;
               $display("FAIL unexpected_beat_a: got tag %0h expected no beat", tag_a);
            end else begin
               e = q_a.pop_front();
               check($sformatf("imm_a tag %0h", e.tag), imm_a, e.imm);
               check("tag_a", tag_a, e.tag);
               check($sformatf("shamt_err_a tag %0h", e.tag), err_a, e.err);
            end
         end
         if (out_valid_b && out_ready_b) begin
            dcyc_b.push_back(cyc);
            if (q_b.size() == 0) begin
               compared++; mismatched++;
               $display("FAIL unexpected_beat_b: got tag %0h expected no beat", tag_b);
            end else begin
               e = q_b.pop_front();
               check($sformatf("imm_b tag %0h", e.tag), imm_b, e.imm);
               check("tag_b", tag_b, e.tag);
               check($sformatf("shamt_err_b tag %0h", e.tag), err_b, e.err);
            end
         end
         hold_a = out_valid_a && !out_ready_a; h_tag_a = tag_a; h_imm_a = imm_a;
         hold_b = out_valid_b && !out_ready_b; h_tag_b = tag_b; h_imm_b = imm_b;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int c0;
      // Hand-computed vectors: sel, inst, expected XLEN=32 imm/err, expected XLEN=64 imm.
      set_vec(0,  3'b000, 32'hFFF00093, 64'hFFFFFFFF, 0, 64'hFFFFFFFFFFFFFFFF);
      set_vec(1,  3'b001, 32'hFFF00093, 64'h00000FFF, 0, 64'h0000000000000FFF);
      set_vec(2,  3'b000, 32'h7FF00013, 64'h000007FF, 0, 64'h00000000000007FF);
      set_vec(3,  3'b010, 32'h02300013, 64'h00000003, 1, 64'h0000000000000023);
      set_vec(4,  3'b000, 32'h02300013, 64'h00000023, 0, 64'h0000000000000023);
      set_vec(5,  3'b010, 32'h01F00013, 64'h0000001F, 0, 64'h000000000000001F);
      set_vec(6,  3'b011, 32'hFE000E23, 64'hFFFFFFFC, 0, 64'hFFFFFFFFFFFFFFFC);
      set_vec(7,  3'b100, 32'hFE000EE3, 64'hFFFFFFFC, 0, 64'hFFFFFFFFFFFFFFFC);
      set_vec(8,  3'b101, 32'h123450B7, 64'h12345000, 0, 64'h0000000012345000);
      set_vec(9,  3'b101, 32'hFFFFF037, 64'hFFFFF000, 0, 64'hFFFFFFFFFFFFF000);
      set_vec(10, 3'b110, 32'h0080006F, 64'h00000008, 0, 64'h0000000000000008);
      set_vec(11, 3'b110, 32'hFFDFF06F, 64'hFFFFFFFC, 0, 64'hFFFFFFFFFFFFFFFC);
      set_vec(12, 3'b111, 32'h000F8073, 64'h0000001F, 0, 64'h000000000000001F);

      rst = 1'b1; in_valid_a = 1'b0; in_valid_b = 1'b0;
      out_ready_a = 1'b1; out_ready_b = 1'b1;
      inst = '0; imm_sel = '0; in_tag = '0;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready_a", in_ready_a, 0);
      check("rst_in_ready_b", in_ready_b, 0);
      check("rst_out_valid_a", out_valid_a, 0);
      check("rst_out_valid_b", out_valid_b, 0);
      check("rst_imm_a", imm_a, 0);
      check("rst_imm_b", imm_b, 0);
      check("rst_tag_a", tag_a, 0);
      check("rst_err_a", err_a, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("post_rst_in_ready_a", in_ready_a, 1);
      check("post_rst_in_ready_b", in_ready_b, 1);

      // Streaming: 16 beats through both DUTs with out_ready held high.
      c0 = cyc;
      for (int i = 0; i < 16; i++) send(1, 1, i % 13, 32'h100 + i);
      check("stream_accept_cycles", cyc - c0, 16);
      repeat (3) @(posedge clk);
      #1;
      check("stream_count_a", dcyc_a.size(), 16);
      check("stream_count_b", dcyc_b.size(), 16);
      if (dcyc_a.size() == 16) check("stream_span_a", dcyc_a[15] - dcyc_a[0], 15);
      if (dcyc_b.size() == 16) check("stream_span_b", dcyc_b[15] - dcyc_b[0], 15);

      // Backpressure on the skid DUT: A in M, B in S, C waits.
      dcyc_a.delete();
      out_ready_a = 1'b0;
      send(1, 0, 0, 32'hA);
      send(1, 0, 6, 32'hB);
      check("bp_in_ready_low", in_ready_a, 0);
      check("bp_head_tag", tag_a, 32'hA);
      fork
         send(1, 0, 3, 32'hC);
         begin
            repeat (2) @(posedge clk);
            #1;
            check("bp_in_ready_still_low", in_ready_a, 0);
            check("bp_out_valid", out_valid_a, 1);
            out_ready_a = 1'b1;
         end
      join
      repeat (3) @(posedge clk);
      #1;
      check("bp_count", dcyc_a.size(), 3);
      if (dcyc_a.size() == 3) check("bp_span", dcyc_a[2] - dcyc_a[0], 2);

      // Reset with M and S both full.
      out_ready_a = 1'b0;
      send(1, 0, 1, 32'hD);
      send(1, 0, 2, 32'hE);
      check("mid_full_in_ready", in_ready_a, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_out_valid", out_valid_a, 0);
      check("mid_rst_imm", imm_a, 0);
      check("mid_rst_tag", tag_a, 0);
      check("mid_rst_err", err_a, 0);
      check("mid_rst_in_ready", in_ready_a, 0);
      q_a.delete(); q_b.delete();
      rst = 1'b0;
      @(posedge clk); #1;
      check("mid_post_in_ready", in_ready_a, 1);
      check("mid_post_out_valid", out_valid_a, 0);
      out_ready_a = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // Traffic resumes normally after reset.
      send(1, 1, 7, 32'hF);
      repeat (3) @(posedge clk);
      #1;
      check("final_q_a_empty", q_a.size(), 0);
      check("final_q_b_empty", q_b.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
